// File: rtl/serial_frame_pkg.sv
// Shared types, default parameters and helpers for the serial frame demultiplexer.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    HDR_CH  = 2'd1,
    HDR_LEN = 2'd2,
    PAYLOAD = 2'd3
  } state_t;

  localparam int         DEF_START_LEN = 4;
  localparam logic [3:0] DEF_START_PAT = 4'b1101;
  localparam int         DEF_CH_BITS   = 2;
  localparam int         DEF_LEN_BITS  = 4;

  // Width of a counter that must reach max(ch_bits, len_bits).
  function automatic int hdr_cnt_w(input int ch_bits, input int len_bits);
    int m;
    m = (ch_bits > len_bits) ? ch_bits : len_bits;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/start_pattern_det.sv
// Start-pattern hunter: tracks the last accepted bits and flags a match on the
// bit that completes the pattern, once enough bits have been seen since clear.
module start_pattern_det
  import serial_frame_pkg::*;
#(
  parameter int                   START_LEN = DEF_START_LEN,
  parameter logic [START_LEN-1:0] START_PAT = DEF_START_PAT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_en,
  input  logic ser_in,
  output logic match
);

  localparam int FW = $clog2(START_LEN + 1);

  // Only START_LEN-1 bits of history are kept; the current bit completes the window.
  logic [START_LEN-2:0] r_hist;
  logic [FW-1:0]        r_fill;
  logic [START_LEN-1:0] w_win;
  logic                 w_full;

  assign w_win  = {r_hist, ser_in};
  assign w_full = (r_fill >= FW'(START_LEN - 1));
  assign match  = bit_en && !clr && w_full && (w_win == START_PAT);

  // Shift history and count fill (saturating) on accepted bits; clear restarts the hunt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (bit_en) begin
      r_hist <= w_win[START_LEN-2:0];
      if (r_fill != FW'(START_LEN)) r_fill <= r_fill + 1'b1;
    end
  end

endmodule

// File: rtl/serial_frame_demux.sv
// Serial frame receiver: hunts a start pattern, captures channel and length
// header fields, then routes payload bits to the addressed channel.
module serial_frame_demux
  import serial_frame_pkg::*;
#(
  parameter int                   START_LEN = DEF_START_LEN,
  parameter logic [START_LEN-1:0] START_PAT = DEF_START_PAT,
  parameter int                   CH_BITS   = DEF_CH_BITS,
  parameter int                   LEN_BITS  = DEF_LEN_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_en,
  input  logic                       ser_in,
  output logic                       ser_out,
  output logic [(1<<CH_BITS)-1:0]    ch_valid,
  output logic [CH_BITS-1:0]         cur_ch,
  output logic                       frame_done,
  output logic                       busy
);

  localparam int NUM_CH = 1 << CH_BITS;
  localparam int HCW    = hdr_cnt_w(CH_BITS, LEN_BITS);

  state_t              r_state, w_state_nxt;
  logic [HCW-1:0]      r_hcnt, w_hcnt_nxt;
  logic [LEN_BITS-1:0] r_len, w_len_nxt;
  logic [LEN_BITS-1:0] r_rem, w_rem_nxt;
  logic [CH_BITS-1:0]  r_cur_ch, w_cur_ch_nxt;
  logic                r_ser_out, w_ser_out_nxt;
  logic [NUM_CH-1:0]   r_ch_valid, w_ch_valid_nxt;
  logic                r_frame_done, w_frame_done_nxt;
  logic                r_busy, w_busy_nxt;

  logic                w_match;
  logic                w_clr;
  logic                w_ch_last;
  logic                w_len_last;
  logic                w_rem_last;
  logic [LEN_BITS-1:0] w_len_full;

  // The detector is held clear outside HUNT so payload bits never seed a match.
  assign w_clr      = (r_state != HUNT);
  assign w_ch_last  = (r_hcnt == HCW'(CH_BITS - 1));
  assign w_len_last = (r_hcnt == HCW'(LEN_BITS - 1));
  assign w_rem_last = (r_rem == LEN_BITS'(1));
  assign w_len_full = (r_len << 1) | LEN_BITS'(ser_in);

  start_pattern_det #(
    .START_LEN (START_LEN),
    .START_PAT (START_PAT)
  ) u_det (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_clr),
    .bit_en (bit_en),
    .ser_in (ser_in),
    .match  (w_match)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= HUNT;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode; advances only on accepted bits.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HUNT:    if (w_match) w_state_nxt = HDR_CH;
      HDR_CH:  if (bit_en && w_ch_last) w_state_nxt = HDR_LEN;
      HDR_LEN: if (bit_en && w_len_last)
                 w_state_nxt = (w_len_full == '0) ? HUNT : PAYLOAD;
      PAYLOAD: if (bit_en && w_rem_last) w_state_nxt = HUNT;
      default: w_state_nxt = HUNT;
    endcase
  end

  // Next values for counters, header fields and registered outputs.
  always_comb begin
    w_hcnt_nxt       = r_hcnt;
    w_len_nxt        = r_len;
    w_rem_nxt        = r_rem;
    w_cur_ch_nxt     = r_cur_ch;
    w_ser_out_nxt    = r_ser_out;
    w_ch_valid_nxt   = '0;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      HUNT: w_hcnt_nxt = '0;
      HDR_CH: if (bit_en) begin
        w_cur_ch_nxt = (r_cur_ch << 1) | CH_BITS'(ser_in);
        w_hcnt_nxt   = w_ch_last ? '0 : r_hcnt + 1'b1;
      end
      HDR_LEN: if (bit_en) begin
        w_len_nxt = w_len_full;
        if (w_len_last) begin
          w_hcnt_nxt = '0;
          if (w_len_full == '0) w_frame_done_nxt = 1'b1;
          else                  w_rem_nxt        = w_len_full;
        end else begin
          w_hcnt_nxt = r_hcnt + 1'b1;
        end
      end
      PAYLOAD: if (bit_en) begin
        w_ser_out_nxt    = ser_in;
        w_ch_valid_nxt   = NUM_CH'(1) << r_cur_ch;
        w_rem_nxt        = r_rem - 1'b1;
        w_frame_done_nxt = w_rem_last;
      end
      default: w_hcnt_nxt = '0;
    endcase
    w_busy_nxt = (w_state_nxt != HUNT);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt       <= '0;
      r_len        <= '0;
      r_rem        <= '0;
      r_cur_ch     <= '0;
      r_ser_out    <= 1'b0;
      r_ch_valid   <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_hcnt       <= w_hcnt_nxt;
      r_len        <= w_len_nxt;
      r_rem        <= w_rem_nxt;
      r_cur_ch     <= w_cur_ch_nxt;
      r_ser_out    <= w_ser_out_nxt;
      r_ch_valid   <= w_ch_valid_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign ser_out    = r_ser_out;
  assign ch_valid   = r_ch_valid;
  assign cur_ch     = r_cur_ch;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_serial_frame_demux.sv
// Directed bench for serial_frame_demux with default parameters.
module tb_serial_frame_demux;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_en = 1'b0;
  logic       ser_in = 1'b0;
  logic       ser_out;
  logic [3:0] ch_valid;
  logic [1:0] cur_ch;
  logic       frame_done;
  logic       busy;

  int total = 0;
  int bad   = 0;

  serial_frame_demux dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .ser_in     (ser_in),
    .ser_out    (ser_out),
    .ch_valid   (ch_valid),
    .cur_ch     (cur_ch),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepted bit; returns 1 time unit after the capturing edge.
  task automatic sb(input logic b);
    @(negedge clk);
    bit_en = 1'b1;
    ser_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic sbits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sb(v[i]);
  endtask

  // One cycle with bit_en low and the line toggled, so an unqualified sample would show.
  task automatic gap1();
    @(negedge clk);
    bit_en = 1'b0;
    ser_in = ~ser_in;
    @(posedge clk);
    #1;
  endtask

  task automatic sbits_slow(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sb(v[i]);
      gap1();
      gap1();
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bit_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ser_out", 32'(ser_out), 32'd0);
    chk("rst_ch_valid", 32'(ch_valid), 32'd0);
    chk("rst_cur_ch", 32'(cur_ch), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: 1101, ch=10, len=0011, payload 101, continuous bit_en
    sbits(16'b110, 3);
    chk("t1_busy_before_match", 32'(busy), 32'd0);
    sb(1'b1);
    chk("t1_busy_after_match", 32'(busy), 32'd1);
    sbits(16'b10, 2);
    chk("t1_cur_ch", 32'(cur_ch), 32'd2);
    sbits(16'b0011, 4);
    chk("t1_no_valid_in_hdr", 32'(ch_valid), 32'd0);
    chk("t1_busy_hdr", 32'(busy), 32'd1);
    sb(1'b1);
    chk("t1_p0_valid", 32'(ch_valid), 32'h4);
    chk("t1_p0_ser", 32'(ser_out), 32'd1);
    chk("t1_p0_done", 32'(frame_done), 32'd0);
    sb(1'b0);
    chk("t1_p1_valid", 32'(ch_valid), 32'h4);
    chk("t1_p1_ser", 32'(ser_out), 32'd0);
    sb(1'b1);
    chk("t1_p2_valid", 32'(ch_valid), 32'h4);
    chk("t1_p2_ser", 32'(ser_out), 32'd1);
    chk("t1_p2_done", 32'(frame_done), 32'd1);
    chk("t1_p2_busy", 32'(busy), 32'd0);
    idle(1);
    chk("t1_after_valid", 32'(ch_valid), 32'd0);
    chk("t1_after_done", 32'(frame_done), 32'd0);
    chk("t1_after_ser_held", 32'(ser_out), 32'd1);
    chk("t1_after_ch_held", 32'(cur_ch), 32'd2);

    // Test 2: zero-length frame
    sbits(16'b1101, 4);
    sbits(16'b01, 2);
    sbits(16'b0000, 3);
    chk("t2_busy_len", 32'(busy), 32'd1);
    sb(1'b0);
    chk("t2_done", 32'(frame_done), 32'd1);
    chk("t2_no_valid", 32'(ch_valid), 32'd0);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_cur_ch", 32'(cur_ch), 32'd1);
    idle(1);
    chk("t2_done_drop", 32'(frame_done), 32'd0);

    // Test 3: overlapping / false start 111101
    sbits(16'b11110, 5);
    chk("t3_no_match_yet", 32'(busy), 32'd0);
    sb(1'b1);
    chk("t3_match_6th", 32'(busy), 32'd1);
    sbits(16'b11, 2);
    sbits(16'b0001, 4);
    sb(1'b0);
    chk("t3_valid", 32'(ch_valid), 32'h8);
    chk("t3_ser", 32'(ser_out), 32'd0);
    chk("t3_done", 32'(frame_done), 32'd1);
    idle(1);
    chk("t3_valid_once", 32'(ch_valid), 32'd0);

    // Test 4: payload containing 1101, then back-to-back frame
    sbits(16'b1101, 4);
    sbits(16'b00, 2);
    sbits(16'b0100, 4);
    sb(1'b1);
    chk("t4_p0", 32'({ch_valid, ser_out}), 32'({4'h1, 1'b1}));
    sb(1'b1);
    chk("t4_p1", 32'({ch_valid, ser_out}), 32'({4'h1, 1'b1}));
    sb(1'b0);
    chk("t4_p2", 32'({ch_valid, ser_out}), 32'({4'h1, 1'b0}));
    chk("t4_p2_busy", 32'(busy), 32'd1);
    sb(1'b1);
    chk("t4_p3", 32'({ch_valid, ser_out}), 32'({4'h1, 1'b1}));
    chk("t4_p3_done", 32'(frame_done), 32'd1);
    chk("t4_p3_busy", 32'(busy), 32'd0);
    sbits(16'b1101, 4);
    chk("t4_f2_match", 32'(busy), 32'd1);
    chk("t4_f2_no_valid", 32'(ch_valid), 32'd0);
    sbits(16'b00, 2);
    sbits(16'b0001, 4);
    sb(1'b1);
    chk("t4_f2_valid", 32'(ch_valid), 32'h1);
    chk("t4_f2_ser", 32'(ser_out), 32'd1);
    chk("t4_f2_done", 32'(frame_done), 32'd1);
    idle(2);

    // Test 5: bit_en every 3rd cycle, same frame as test 1
    sbits_slow(16'b1101, 4);
    sbits_slow(16'b10, 2);
    sbits_slow(16'b0011, 4);
    sb(1'b1);
    chk("t5_p0_valid", 32'(ch_valid), 32'h4);
    chk("t5_p0_ser", 32'(ser_out), 32'd1);
    gap1();
    chk("t5_p0_width", 32'(ch_valid), 32'd0);
    chk("t5_p0_ser_held", 32'(ser_out), 32'd1);
    gap1();
    chk("t5_p0_busy", 32'(busy), 32'd1);
    sb(1'b0);
    chk("t5_p1_valid", 32'(ch_valid), 32'h4);
    chk("t5_p1_ser", 32'(ser_out), 32'd0);
    gap1();
    chk("t5_p1_width", 32'(ch_valid), 32'd0);
    chk("t5_p1_ser_held", 32'(ser_out), 32'd0);
    gap1();
    sb(1'b1);
    chk("t5_p2_valid", 32'(ch_valid), 32'h4);
    chk("t5_p2_ser", 32'(ser_out), 32'd1);
    chk("t5_p2_done", 32'(frame_done), 32'd1);
    gap1();
    chk("t5_p2_done_width", 32'(frame_done), 32'd0);
    chk("t5_p2_busy", 32'(busy), 32'd0);
    gap1();

    // Test 6: reset during 2nd payload bit, then a clean frame
    sbits(16'b1101, 4);
    sbits(16'b10, 2);
    sbits(16'b0011, 4);
    sb(1'b1);
    chk("t6_p0_valid", 32'(ch_valid), 32'h4);
    @(negedge clk);
    bit_en = 1'b1;
    ser_in = 1'b0;
    rst    = 1'b1;
    #1;
    chk("t6_rst_ser", 32'(ser_out), 32'd0);
    chk("t6_rst_valid", 32'(ch_valid), 32'd0);
    chk("t6_rst_cur_ch", 32'(cur_ch), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("t6_rst_no_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    bit_en = 1'b0;
    sbits(16'b1101, 4);
    sbits(16'b11, 2);
    sbits(16'b0001, 4);
    sb(1'b1);
    chk("t6_f2_valid", 32'(ch_valid), 32'h8);
    chk("t6_f2_ser", 32'(ser_out), 32'd1);
    chk("t6_f2_done", 32'(frame_done), 32'd1);
    chk("t6_f2_cur_ch", 32'(cur_ch), 32'd3);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_demux.md
Name: serial_frame_demux

Overview:
Parametrised serial frame receiver and channel demultiplexer.
- Hunts a configurable start pattern on a 1-bit serial line.
- Then captures a channel-ID field and a payload-length field.
- Then routes exactly that many payload bits to the addressed channel, with a per-channel valid strobe.
- Bits are qualified by a bit-enable strobe, so the block runs on a system clock faster than the line rate.
- Sits between the serial line front end and the per-channel consumers.

Parameters:
START_LEN, 4, number of bits in the start pattern (2..8)
START_PAT, 4'b1101, start pattern, MSB received first
CH_BITS, 2, width of the channel-ID field; NUM_CH = 2**CH_BITS
LEN_BITS, 4, width of the payload-length field; payload 0..2**LEN_BITS-1 bits

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
bit_en  in  1  serial bit strobe; ser_in sampled only when 1
ser_in  in  1  serial data line
ser_out  out  1  registered copy of last accepted payload bit
ch_valid  out  NUM_CH  one-hot; bit [ch] high 1 cycle per payload bit
cur_ch  out  CH_BITS  channel of frame in progress (held until next header)
frame_done  out  1  1-cycle pulse at frame end
busy  out  1  high in any state other than HUNT

Behaviour:
- Reset values:
  - state=HUNT.
  - ser_out=0, ch_valid=0, cur_ch=0, frame_done=0, busy=0.
  - Pattern history cleared, counters=0.
- All outputs are registered. Nothing changes on cycles with bit_en=0, except that 1-cycle pulses (ch_valid, frame_done) drop.
- Fields are received MSB first.
- HUNT:
  - Each accepted bit shifts into a START_LEN-bit history.
  - Match: the history (including the current bit) equals START_PAT, with at least START_LEN bits accepted since entering HUNT.
  - On match -> HDR_CH, with bit counter cleared.
  - Overlapping patterns are detected.
- HDR_CH: shift CH_BITS bits into cur_ch. After the CH_BITS-th bit -> HDR_LEN.
- HDR_LEN:
  - Shift LEN_BITS bits into a length register.
  - After the last bit: if length==0, pulse frame_done next cycle and go to HUNT. Otherwise go to PAYLOAD with remaining = length.
- PAYLOAD:
  - Each accepted bit: next cycle ser_out=bit and ch_valid=(1<<cur_ch) for exactly 1 cycle; remaining decrements.
  - When the bit taking remaining 1->0 is accepted: frame_done pulses in the same cycle as that bit's ch_valid, and the state returns to HUNT.
- Latency: 1 clk from the accepted payload bit to ch_valid/ser_out.
- On entry to HUNT, the pattern history and fill count are cleared. Payload bits of a finished frame can never complete a start pattern.
- Back-to-back frames: a start pattern may begin on the bit immediately after the last payload bit.
- Start pattern bits inside header or payload are treated as data; no resync mid-frame.
- bit_en may be held high continuously (1 bit per clk) or pulsed arbitrarily. Gaps of any length are legal.
- rst asserted mid-frame: immediate return to reset values. A partial frame is discarded with no frame_done.
- Counters: header counter width clog2(max(CH_BITS, LEN_BITS)+1); payload counter LEN_BITS wide. No wrap possible.
- Illegal state encodings -> HUNT.

Decomposition:
- Package serial_frame_pkg:
  - State enum with states HUNT, HDR_CH, HDR_LEN, PAYLOAD.
  - Default parameter constants.
  - Function for clog2-based counter width.
- Sub-module start_pattern_det (parametrised by START_LEN and START_PAT). Ports: clk, rst, clr, bit_en, ser_in, match.
- The FSM, counters and output registers live in serial_frame_demux.

Test Plan:
1. Defaults, bit_en=1 continuous. Send 1101, ch=10, len=0011, payload 101.
   -> ch_valid=4'b0100 on 3 cycles with ser_out 1,0,1; frame_done with the 3rd strobe; busy falls next cycle.
2. Length 0: send 1101, 01, 0000.
   -> no ch_valid; frame_done pulses 1 cycle after the last length bit; back to HUNT.
3. Overlap and false start: send 1 1 1 1 0 1 then ch=11, len=0001, bit 0.
   -> pattern detected on the 6th bit; ch_valid=4'b1000 once with ser_out=0.
4. Payload containing 1101: len=0100, payload 1101, followed immediately by a new frame 1101,00,0001,1.
   -> payload routed without resync; second frame delivers ch_valid=4'b0001 once with ser_out=1.
5. bit_en every 3rd cycle, same frame as test 1.
   -> identical ch_valid/ser_out sequence; each strobe exactly 1 clk wide; outputs held between strobes.
6. Assert rst during the 2nd payload bit of test 1.
   -> all outputs 0 immediately, no frame_done; a subsequent valid frame is received correctly.
